// File: rtl/if_stage_pkg.sv
// if_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetchState_t : fetch FSM encoding (FETCH / HOLD / DRAIN)
//   - NOP_INSTR    : instruction word placed in IF/ID for a bubble
//   - RESET_PC     : default program counter after reset
package if_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at pc
    HOLD  = 2'd1,  // fetched word parked in buffer while ID stalls
    DRAIN = 2'd2   // wrong-path request still outstanding, redirect pending
  } fetchState_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if
// Ready-handshaked instruction-memory port.
//   imem_req   : fetch request, held stable with imem_addr until imem_ready
//   imem_addr  : word-aligned fetch address
//   imem_ready : transfer completes this cycle, imem_rdata valid
//   imem_rdata : fetched instruction word
// master = fetch stage, slave = instruction memory.
interface if_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_stage_if_id_pipe_reg.sv
// if_id_pipe_reg
// IF/ID pipeline register: pc+4, instruction word and valid flag.
//   clk, rst          : clock, synchronous active-high reset (loads a bubble)
//   load              : capture pc4In / instrIn as a valid instruction
//   hold              : keep current contents
//   flush             : load a bubble; wins over hold and load
//   pc4In, instrIn    : data captured on load
//   pc_4, instruction, id_valid : register contents seen by ID
import if_stage_pkg::*;

module if_id_pipe_reg #(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] pc4In,
  input  logic [31:0] instrIn,
  output logic [31:0] pc_4,
  output logic [31:0] instruction,
  output logic        id_valid
);

  logic [31:0] pc4Reg;
  logic [31:0] instrReg;
  logic        validReg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pc4Reg   <= 32'h0000_0000;
      instrReg <= BUBBLE_INSTR;
      validReg <= 1'b0;
    end else if (hold) begin
      pc4Reg   <= pc4Reg;
      instrReg <= instrReg;
      validReg <= validReg;
    end else if (load) begin
      pc4Reg   <= pc4In;
      instrReg <= instrIn;
      validReg <= 1'b1;
    end
  end

  assign pc_4        = pc4Reg;
  assign instruction = instrReg;
  assign id_valid    = validReg;

endmodule

// File: rtl/if_stage.sv
// if_stage
// Instruction-fetch stage feeding ID. Owns the PC, drives the instruction
// memory port and holds the IF/ID register.
//   clk, rst            : clock, synchronous active-high reset
//   shouldStall         : ID hazard stall, hold PC and IF/ID
//   shouldJumpOrBranch  : ID redirect request (ignored while stalled)
//   jumpOrBranchPc      : redirect target, low two bits dropped
//   imem (master)       : ready-handshaked instruction-memory port
//   pc_4, instruction, id_valid : IF/ID register outputs
//   debug_pc            : current PC (address being or next to be fetched)
// No delay slot: anything fetched on the wrong path is squashed.
import if_stage_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC  = if_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] jumpOrBranchPc,
  if_stage_if.master  imem,
  output logic [31:0] pc_4,
  output logic [31:0] instruction,
  output logic        id_valid,
  output logic [31:0] debug_pc
);

  fetchState_t stateReg;
  logic [31:0] pcReg;
  logic [31:0] bufReg;
  logic [31:0] pendReg;
  logic        reqReg;

  logic        redirect;
  logic [31:0] targetPc;
  logic [31:0] pcPlus4;
  logic        done;

  // Stall masks the redirect; ID will re-present it once the stall clears.
  assign redirect = shouldJumpOrBranch & ~shouldStall;
  assign targetPc = jumpOrBranchPc & ~32'h0000_0003;
  assign pcPlus4  = pcReg + 32'd4;
  assign done     = reqReg & imem.imem_ready;

  // reqReg tracks FETCH/DRAIN; rst gates it so no request leaves in reset.
  assign imem.imem_req  = reqReg & ~rst;
  assign imem.imem_addr = pcReg;
  assign debug_pc       = pcReg;

  // Fetch FSM. In DRAIN pcReg keeps the old address so the outstanding
  // request stays stable; the redirect target waits in pendReg.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= FETCH;
      pcReg    <= RESET_PC;
      bufReg   <= NOP_INSTR;
      pendReg  <= 32'h0000_0000;
      reqReg   <= 1'b1;
    end else begin
      case (stateReg)
        FETCH: begin
          if (redirect) begin
            if (imem.imem_ready) begin
              pcReg <= targetPc;
            end else begin
              pendReg  <= targetPc;
              stateReg <= DRAIN;
            end
          end else if (shouldStall) begin
            if (imem.imem_ready) begin
              bufReg   <= imem.imem_rdata;
              stateReg <= HOLD;
              reqReg   <= 1'b0;
            end
          end else if (imem.imem_ready) begin
            pcReg <= pcPlus4;
          end
        end
        HOLD: begin
          if (redirect) begin
            pcReg    <= targetPc;
            stateReg <= FETCH;
            reqReg   <= 1'b1;
          end else if (!shouldStall) begin
            pcReg    <= pcPlus4;
            stateReg <= FETCH;
            reqReg   <= 1'b1;
          end
        end
        DRAIN: begin
          if (redirect) begin
            pendReg <= targetPc;
          end
          if (done) begin
            // A redirect landing on the completion cycle is the newest target.
            pcReg    <= redirect ? targetPc : pendReg;
            stateReg <= FETCH;
          end
        end
        default: begin
          stateReg <= FETCH;
          reqReg   <= 1'b1;
        end
      endcase
    end
  end

  // IF/ID control mirrors the FSM decisions above.
  logic        pipeLoad;
  logic        pipeHold;
  logic        pipeFlush;
  logic [31:0] pipeInstr;

  always_comb begin
    pipeLoad  = 1'b0;
    pipeHold  = 1'b0;
    pipeFlush = 1'b0;
    pipeInstr = imem.imem_rdata;
    case (stateReg)
      FETCH: begin
        if (redirect)              pipeFlush = 1'b1;
        else if (shouldStall)      pipeHold  = 1'b1;
        else if (imem.imem_ready)  pipeLoad  = 1'b1;
        else                       pipeFlush = 1'b1;
      end
      HOLD: begin
        pipeInstr = bufReg;
        if (redirect)              pipeFlush = 1'b1;
        else if (shouldStall)      pipeHold  = 1'b1;
        else                       pipeLoad  = 1'b1;
      end
      DRAIN: begin
        if (shouldStall)           pipeHold  = 1'b1;
        else                       pipeFlush = 1'b1;
      end
      default: pipeFlush = 1'b1;
    endcase
  end

  if_id_pipe_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_ifIdReg (
    .clk        (clk),
    .rst        (rst),
    .load       (pipeLoad),
    .hold       (pipeHold),
    .flush      (pipeFlush),
    .pc4In      (pcPlus4),
    .instrIn    (pipeInstr),
    .pc_4       (pc_4),
    .instruction(instruction),
    .id_valid   (id_valid)
  );

endmodule
